zoom_addr_pipe: RTL and testbench

- Parametrised, pipelined successor to the combinational zoom coordinate/address unit.
- Maps each VGA screen pixel (x_in, y_in) to a source-image coordinate and frame-buffer address, for zoom factors 1/4x, 1/2x, 1x, 2x and 4x.
- Zoom is centre-anchored: the image centre stays fixed at the screen centre.
- Sits between the VGA pixel scanner and the frame-buffer read port. Uses valid/ready on both sides and a drained, handshaken zoom-mode change.

---
 rtl/zoom_pkg.sv | 29 ++
 rtl/zoom_axis_map.sv | 34 +++
 rtl/zoom_addr_pipe.sv | 148 ++++++++++++++
 tb/tb_zoom_addr_pipe.sv | 385 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/zoom_pkg.sv
// Shared types and default geometry for the zoom address pipeline.
package zoom_pkg;

  typedef enum logic [2:0] {
    ZOOM_1X   = 3'b000,
    ZOOM_IN2  = 3'b001,
    ZOOM_IN4  = 3'b010,
    ZOOM_OUT2 = 3'b011,
    ZOOM_OUT4 = 3'b100
  } zoom_op_t;

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    COMMIT
  } fsm_t;

  localparam int DEF_IMG_W   = 320;
  localparam int DEF_IMG_H   = 240;
  localparam int DEF_SCR_W   = 640;
  localparam int DEF_SCR_H   = 480;
  localparam int DEF_BG_ADDR = 43385;

  // Reserved encodings fall back to unity zoom.
  function automatic zoom_op_t norm_op(logic [2:0] op);
    return (op > 3'b100) ? ZOOM_1X : zoom_op_t'(op);
  endfunction

endpackage

// File: rtl/zoom_axis_map.sv
// Single-axis mapper: centred screen offset to source coordinate.
module zoom_axis_map
  import zoom_pkg::*;
#(
  parameter int CW = 10,
  parameter int W  = CW + 3
) (
  input  logic signed [W-1:0]  r,
  input  zoom_op_t             mode,
  input  logic signed [W-1:0]  half_size,
  input  logic signed [W-1:0]  size,
  output logic [CW-1:0]        s,
  output logic                 inside_img
);

  logic signed [W-1:0] sc;
  logic signed [W-1:0] sf;

  always_comb begin
    sc = r;
    unique case (mode)
      ZOOM_IN2:  sc = r >>> 1;
      ZOOM_IN4:  sc = r >>> 2;
      ZOOM_OUT2: sc = r <<< 1;
      ZOOM_OUT4: sc = r <<< 2;
      default:   sc = r;
    endcase
  end

  assign sf = sc + half_size;
  assign inside_img = !sf[W-1] && (sf < size);
  assign s = sf[CW-1:0];

endmodule

// File: rtl/zoom_addr_pipe.sv
// Three-stage screen-to-frame-buffer address pipeline with
// drained, handshaken zoom-mode changes.
module zoom_addr_pipe
  import zoom_pkg::*;
#(
  parameter int IMG_W   = DEF_IMG_W,
  parameter int IMG_H   = DEF_IMG_H,
  parameter int SCR_W   = DEF_SCR_W,
  parameter int SCR_H   = DEF_SCR_H,
  parameter int COORD_W = 10,
  parameter int ADDR_W  = 17,
  parameter logic [ADDR_W-1:0] BG_ADDR = ADDR_W'(DEF_BG_ADDR)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [COORD_W-1:0] x_in,
  input  logic [COORD_W-1:0] y_in,
  input  logic [2:0]         op,
  input  logic               op_req,
  output logic               zoom_done,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [COORD_W-1:0] x_out,
  output logic [COORD_W-1:0] y_out,
  output logic               in_image,
  output logic [ADDR_W-1:0]  address
);

  localparam int W = COORD_W + 3;
  typedef logic signed [W-1:0] sw_t;

  fsm_t     state, state_nx;
  zoom_op_t mode, pending;

  logic adv, accept, drained;

  logic     v1, v2;
  sw_t      rx1, ry1;
  zoom_op_t m1;

  logic [COORD_W-1:0] sx, sy, sx2, sy2;
  logic               hx, hy, in2;

  assign adv       = !out_valid || out_ready;
  assign accept    = in_valid && in_ready;
  assign drained   = !v1 && !v2 && !out_valid;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= RUN;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    zoom_done = 1'b0;
    unique case (state)
      RUN: begin
        in_ready = adv;
        if (op_req) state_nx = DRAIN;
      end
      DRAIN: begin
        if (drained) state_nx = COMMIT;
      end
      COMMIT: begin
        zoom_done = 1'b1;
        state_nx  = RUN;
      end
      default: state_nx = RUN;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mode    <= ZOOM_1X;
      pending <= ZOOM_1X;
    end else begin
      if (op_req && state != COMMIT) pending <= norm_op(op);
      if (state == COMMIT)           mode    <= pending;
    end
  end

  zoom_axis_map #(.CW(COORD_W)) u_map_x (
    .r          (rx1),
    .mode       (m1),
    .half_size  (sw_t'(IMG_W / 2)),
    .size       (sw_t'(IMG_W)),
    .s          (sx),
    .inside_img (hx)
  );

  zoom_axis_map #(.CW(COORD_W)) u_map_y (
    .r          (ry1),
    .mode       (m1),
    .half_size  (sw_t'(IMG_H / 2)),
    .size       (sw_t'(IMG_H)),
    .s          (sy),
    .inside_img (hy)
  );

  // Each beat carries the mode sampled at acceptance.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      v1        <= 1'b0;
      rx1       <= '0;
      ry1       <= '0;
      m1        <= ZOOM_1X;
      v2        <= 1'b0;
      sx2       <= '0;
      sy2       <= '0;
      in2       <= 1'b0;
      out_valid <= 1'b0;
      x_out     <= '0;
      y_out     <= '0;
      in_image  <= 1'b0;
      address   <= BG_ADDR;
    end else if (adv) begin
      v1 <= accept;
      if (accept) begin
        rx1 <= sw_t'({3'b000, x_in}) - sw_t'(SCR_W / 2);
        ry1 <= sw_t'({3'b000, y_in}) - sw_t'(SCR_H / 2);
        m1  <= mode;
      end
      v2 <= v1;
      if (v1) begin
        sx2 <= sx;
        sy2 <= sy;
        in2 <= hx && hy;
      end
      out_valid <= v2;
      if (v2) begin
        in_image <= in2;
        if (in2) begin
          x_out   <= sx2;
          y_out   <= sy2;
          address <= ADDR_W'(sy2) * ADDR_W'(IMG_W) + ADDR_W'(sx2);
        end else begin
          x_out   <= '0;
          y_out   <= '0;
          address <= BG_ADDR;
        end
      end
    end
  end

endmodule

// File: tb/tb_zoom_addr_pipe.sv
// Scoreboard bench for zoom_addr_pipe with an arithmetic reference model.
module tb_zoom_addr_pipe;
  import zoom_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        op_req = 1'b0;
  logic        out_ready = 1'b1;
  logic [9:0]  x_in = '0;
  logic [9:0]  y_in = '0;
  logic [2:0]  op = '0;
  logic        in_ready, zoom_done, out_valid, in_image;
  logic [9:0]  x_out, y_out;
  logic [16:0] address;

  zoom_addr_pipe dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x_in      (x_in),
    .y_in      (y_in),
    .op        (op),
    .op_req    (op_req),
    .zoom_done (zoom_done),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .x_out     (x_out),
    .y_out     (y_out),
    .in_image  (in_image),
    .address   (address)
  );

  always #5 clock = ~clock;

  typedef struct {
    int x;
    int y;
    int img;
    int addr;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  int   tb_mode = 0;
  int   pend = 0;
  int   done_cnt = 0;
  bit   rdy_rand = 0;

  function automatic int fdiv(int a, int d);
    if (a >= 0) return a / d;
    return -((-a + d - 1) / d);
  endfunction

  function automatic exp_t mk(int x, int y, int i, int a);
    exp_t e;
    e.x = x; e.y = y; e.img = i; e.addr = a;
    return e;
  endfunction

  function automatic exp_t model(int x, int y, int m);
    int rx, ry, sx, sy;
    bit hit;
    rx = x - 320;
    ry = y - 240;
    case (m)
      1: begin sx = fdiv(rx, 2); sy = fdiv(ry, 2); end
      2: begin sx = fdiv(rx, 4); sy = fdiv(ry, 4); end
      3: begin sx = rx * 2; sy = ry * 2; end
      4: begin sx = rx * 4; sy = ry * 4; end
      default: begin sx = rx; sy = ry; end
    endcase
    sx = sx + 160;
    sy = sy + 120;
    hit = (sx >= 0) && (sx < 320) && (sy >= 0) && (sy < 240);
    if (hit) return mk(sx, sy, 1, sy * 320 + sx);
    return mk(0, 0, 0, 43385);
  endfunction

  function automatic int norm(int o);
    return (o > 4) ? 0 : o;
  endfunction

  task automatic chk(string name, longint act, longint req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic timeout(string name);
    tests++;
    fails++;
    $display("FAIL %s: timed out, got no event, required one", name);
  endtask

  // Monitor: scoreboard pop, hold-stability, zoom_done tracking.
  initial begin
    bit          hold;
    logic [9:0]  hx, hy;
    logic [16:0] ha;
    logic        hi;
    exp_t        e;
    hold = 0;
    forever begin
      @(negedge clock);
      if (reset) begin
        hold = 0;
      end else begin
        if (zoom_done) begin
          done_cnt++;
          tb_mode = pend;
        end
        if (hold && out_valid) begin
          chk("hold_x", x_out, hx);
          chk("hold_y", y_out, hy);
          chk("hold_addr", address, ha);
          chk("hold_img", in_image, hi);
        end
        if (out_valid && out_ready) begin
          if (q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_out: got beat addr %0d, required none", address);
          end else begin
            e = q.pop_front();
            chk("x_out", x_out, e.x);
            chk("y_out", y_out, e.y);
            chk("in_image", in_image, e.img);
            chk("address", address, e.addr);
          end
        end
        hold = out_valid && !out_ready;
        hx = x_out; hy = y_out; ha = address; hi = in_image;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clock);
      #1;
      if (rdy_rand) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic send(int x, int y, exp_t e);
    @(posedge clock);
    #1;
    in_valid = 1'b1;
    x_in = 10'(x);
    y_in = 10'(y);
    for (int n = 0; ; n++) begin
      @(negedge clock);
      if (in_ready) break;
      if (n > 400) begin
        timeout("accept");
        in_valid = 1'b0;
        return;
      end
    end
    q.push_back(e);
  endtask

  task automatic send_m(int x, int y);
    send(x, y, model(x, y, tb_mode));
  endtask

  task automatic idle();
    @(posedge clock);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_empty();
    for (int n = 0; ; n++) begin
      @(negedge clock);
      if (q.size() == 0 && !out_valid) break;
      if (n > 600) begin
        timeout("drain_queue");
        return;
      end
    end
  endtask

  task automatic change_mode(int o);
    int d0;
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    op = 3'(o);
    op_req = 1'b1;
    pend = norm(o);
    d0 = done_cnt;
    @(posedge clock);
    #1;
    op_req = 1'b0;
    for (int n = 0; ; n++) begin
      @(negedge clock);
      if (done_cnt != d0) break;
      if (n > 600) begin
        timeout("zoom_done");
        return;
      end
    end
    repeat (3) @(negedge clock);
    chk("zoom_done_pulses", done_cnt - d0, 1);
  endtask

  task automatic check_reset_state();
    @(negedge clock);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_zoom_done", zoom_done, 0);
    chk("rst_address", address, 43385);
    chk("rst_in_image", in_image, 0);
    chk("rst_x_out", x_out, 0);
  endtask

  task automatic hit_reset();
    #2;
    reset = 1'b1;
    in_valid = 1'b0;
    op_req = 1'b0;
    q.delete();
    tb_mode = 0;
    pend = 0;
    check_reset_state();
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    int lat, d0;
    #2000000;
    $display("FAIL watchdog: simulation time exhausted, required completion");
    $fatal(1);
  end

  initial begin
    int lat, d0;
    check_reset_state();
    @(posedge clock);
    #1;
    reset = 1'b0;

    send(160, 120, mk(0, 0, 1, 0));
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    lat = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clock);
      lat++;
      if (out_valid) break;
    end
    chk("latency", lat, 3);
    send(479, 359, mk(319, 239, 1, 76799));
    idle();
    wait_empty();

    change_mode(1);
    send(320, 240, mk(160, 120, 1, 38560));
    send(0, 0, mk(0, 0, 1, 0));
    send(639, 479, mk(319, 239, 1, 76799));
    change_mode(3);
    send(399, 240, mk(318, 120, 1, 38718));
    send(400, 240, mk(0, 0, 0, 43385));
    change_mode(4);
    send(320, 240, mk(160, 120, 1, 38560));
    idle();
    wait_empty();

    change_mode(0);
    fork
      begin
        for (int i = 0; i < 8; i++) send_m(i * 80 + 5, i * 60 + 3);
        idle();
      end
      begin
        out_ready = 1'b1;
        repeat (4) @(posedge clock);
        #1 out_ready = 1'b0;
        repeat (4) @(posedge clock);
        #1 out_ready = 1'b1;
      end
    join
    wait_empty();

    // Mode change with three beats in flight, re-requested mid-drain.
    d0 = done_cnt;
    send_m(100, 50);
    send_m(500, 400);
    send_m(320, 240);
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    op = 3'(ZOOM_IN2);
    op_req = 1'b1;
    pend = 1;
    @(posedge clock);
    #1;
    op_req = 1'b0;
    @(negedge clock);
    chk("drain_in_ready", in_ready, 0);
    @(posedge clock);
    #1;
    op = 3'(ZOOM_OUT4);
    op_req = 1'b1;
    pend = 4;
    @(negedge clock);
    chk("drain_in_ready", in_ready, 0);
    @(posedge clock);
    #1;
    op_req = 1'b0;
    for (int n = 0; ; n++) begin
      @(negedge clock);
      chk("drain_in_ready", in_ready, 0);
      if (zoom_done) break;
      if (n > 100) begin
        timeout("drain_commit");
        break;
      end
    end
    repeat (3) @(negedge clock);
    chk("drain_done_pulses", done_cnt - d0, 1);
    send(330, 240, mk(200, 120, 1, 38600));
    idle();
    wait_empty();

    // Reset mid-stream.
    d0 = done_cnt;
    for (int i = 0; i < 5; i++)
      send_m($urandom_range(0, 639), $urandom_range(0, 479));
    hit_reset();
    repeat (10) @(negedge clock);
    chk("no_done_after_rst", done_cnt, d0);
    send(160, 120, mk(0, 0, 1, 0));
    idle();
    wait_empty();

    // Reset mid-drain.
    change_mode(1);
    d0 = done_cnt;
    for (int i = 0; i < 3; i++)
      send_m($urandom_range(0, 639), $urandom_range(0, 479));
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    op = 3'(ZOOM_OUT2);
    op_req = 1'b1;
    pend = 3;
    @(posedge clock);
    #1;
    op_req = 1'b0;
    @(negedge clock);
    chk("drain2_in_ready", in_ready, 0);
    hit_reset();
    repeat (10) @(negedge clock);
    chk("no_done_after_rst2", done_cnt, d0);
    send(479, 359, mk(319, 239, 1, 76799));
    idle();
    wait_empty();

    // Randomised traffic, back-pressure and mode changes.
    rdy_rand = 1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 39) == 0) change_mode($urandom_range(0, 7));
      send_m($urandom_range(0, 639), $urandom_range(0, 479));
      if ($urandom_range(0, 3) == 0) idle();
    end
    idle();
    rdy_rand = 0;
    #2;
    out_ready = 1'b1;
    wait_empty();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
